seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand and result width.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: A  input  DATA_WIDTH  operand to shift.
REQ-007 Port: B  input  DATA_WIDTH  shift amount; only B[4:0] is used.
REQ-008 Port: Shiftop  input  2  00 = SLL, 10 = SRL, 11 = SRA, 01 = reserved.
REQ-009 Port: out_valid  output  1  Result valid.
REQ-010 Port: out_ready  input  1  consumer accepts Result.
REQ-011 Port: Result  output  DATA_WIDTH  shifted value.

Function
REQ-012 The block SHALL be a multi-cycle shifter that moves exactly one bit position per cycle, using states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-014 On an IDLE edge with in_valid=1, the block SHALL latch A, Shiftop and n=B[4:0].
REQ-015 After that accepting edge, the next state SHALL be SHIFT if n>0 and DONE if n=0.
REQ-016 Each SHIFT edge SHALL perform one step and decrement the counter.
REQ-017 A step SHALL be: SLL shifts left and fills 0; SRL shifts right and fills 0; SRA shifts right and fills the current MSB.
REQ-018 SHIFT SHALL go to DONE on the edge that performs the n-th step.
REQ-019 out_valid SHALL rise exactly n+1 edges after the accepting edge, covering n = 0..31.
REQ-020 In DONE, Result SHALL hold stable until the edge with out_ready=1, which SHALL return the block to IDLE.
REQ-021 Result SHALL be 0 whenever out_valid=0.
REQ-022 There SHALL be no overlap between requests: a new request is accepted no earlier than the edge after the DONE handshake.
REQ-023 in_valid SHALL be ignored outside IDLE; A, B and Shiftop SHALL NOT be sampled after the accepting edge.
REQ-024 Without the configuration macro, Shiftop 01 SHALL produce Result=0 after n+1 edges, with normal handshake.

Reset
REQ-025 While rst=1: state SHALL be IDLE, in_ready=0, out_valid=0, Result=0, counter=0, data register=0.
REQ-026 On the first edge with rst=0, in_ready SHALL be 1.
REQ-027 rst asserted in SHIFT or DONE SHALL abort the operation with no out_valid pulse, including when out_ready=1 on the same edge.

Configuration
REQ-028 With macro SHIFT_ROTATE_EN defined, Shiftop 01 SHALL perform rotate-right by one per step (LSB into MSB), with the same latency.
REQ-029 Without SHIFT_ROTATE_EN, REQ-024 SHALL apply and no rotate logic SHALL be present.

Structure
REQ-030 A shared package SHALL hold DATA_WIDTH, the Shiftop encodings (SHIFTLEFT 00, SHIFTRIGHT 10, SHIFTRIGHTA 11, ROTR 01) and the IDLE/SHIFT/DONE state encoding.
REQ-031 One combinational sub-module, shift_step, SHALL compute a single one-bit step from data and op.
REQ-032 The FSM, counter and handshake SHALL live in seq_shifter.

Verification
REQ-033 The bench SHALL cover: A=0x0000_0001, B=31, SLL -> Result 0x8000_0000, with out_valid 32 edges after accept.
REQ-034 The bench SHALL cover: A=0x8000_0000, B=4, SRA -> 0xF800_0000; same A with SRL -> 0x0800_0000; both after 5 edges.
REQ-035 The bench SHALL cover: A=0x1234_5678, B=0x0000_0020 (B[4:0]=0), SLL -> 0x1234_5678 after 1 edge.
REQ-036 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> Result stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-037 The bench SHALL cover: rst pulsed mid-SHIFT (B=20, pulse at step 7) -> no out_valid; a following request A=0xF0, B=4, SRL -> 0x0F.
REQ-038 The bench SHALL cover Shiftop 01 with A=0x0000_0003, B=1: with SHIFT_ROTATE_EN -> 0x8000_0001; without it -> 0x0000_0000.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg -- shared definitions for the sequential shifter.
// Holds the default data width, the Shiftop encodings and the FSM state
// encoding used by seq_shifter and shift_step.
// Optional feature macro: SHIFT_ROTATE_EN (enables rotate-right for ROTR).
package seq_shifter_pkg;

  localparam int DATA_WIDTH = 32;

  // Shiftop encodings as seen on the request port.
  typedef enum logic [1:0] {
    SHIFTLEFT   = 2'b00,
    ROTR        = 2'b01,
    SHIFTRIGHT  = 2'b10,
    SHIFTRIGHTA = 2'b11
  } shift_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step -- combinational single-bit shift step.
// Ports:
//   data     : current operand value
//   op       : shift operation (SHIFTLEFT / SHIFTRIGHT / SHIFTRIGHTA / ROTR)
//   step_out : operand moved by exactly one bit position
// Optional feature macro: SHIFT_ROTATE_EN. When undefined, ROTR yields zero
// and no rotate path exists.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = seq_shifter_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  shift_op_e             op,
  output logic [DATA_WIDTH-1:0] step_out
);

  always_comb begin
    step_out = '0;
    case (op)
      SHIFTLEFT:   step_out = {data[DATA_WIDTH-2:0], 1'b0};
      SHIFTRIGHT:  step_out = {1'b0, data[DATA_WIDTH-1:1]};
      // Arithmetic right shift replicates the current MSB.
      SHIFTRIGHTA: step_out = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      // The LSB wraps around into the MSB.
      ROTR:        step_out = {data[0], data[DATA_WIDTH-1:1]};
`endif
      default:     step_out = '0;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter -- multi-cycle shifter moving one bit position per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (A, B[4:0], Shiftop)
//   A                   : operand, B : shift amount (only B[4:0] used)
//   Shiftop             : 00 SLL, 10 SRL, 11 SRA, 01 ROTR / reserved
//   out_valid/out_ready : result handshake, Result : shifted value
// Optional feature macro: SHIFT_ROTATE_EN. When defined, Shiftop 01 rotates
// right one bit per step; otherwise Shiftop 01 returns zero with the usual
// latency and handshake.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = seq_shifter_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            Shiftop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result
);

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  shift_op_e             op_q, op_d;
  logic [DATA_WIDTH-1:0] step_data;

  // Upper bits of B never influence the shift amount.
  logic unused_b_hi;
  assign unused_b_hi = ^B[DATA_WIDTH-1:5];

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .data     (data_q),
    .op       (op_q),
    .step_out (step_data)
  );

  // Outputs are gated by rst so a reset edge can never expose a result.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign Result    = out_valid ? data_q : '0;

  // Next-state logic: capture on accept, one step per SHIFT cycle, hold in
  // DONE until the consumer takes the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = A;
`ifndef SHIFT_ROTATE_EN
          // Reserved op: the result is defined as zero even for n = 0.
          if (Shiftop == ROTR) data_d = '0;
`endif
          op_d    = shift_op_e'(Shiftop);
          cnt_d   = B[4:0];
          state_d = (B[4:0] == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      op_q    <= SHIFTLEFT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter -- self-checking bench for seq_shifter.
// A behavioural model predicts handshake signals and Result from plain
// shift arithmetic; directed requests also carry literal expectations.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  Shiftop = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  // Model state: busy counts remaining shift edges, done means result held.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_res = '0;

  seq_shifter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Shiftop   (Shiftop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  // Final value of a whole n-bit shift, computed in one go.
  function automatic logic [31:0] model_result(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [1:0] op);
    int n;
    logic [63:0] t;
    n = int'(b[4:0]);
    t = '0;
    case (op)
      2'b00: return a << n;
      2'b10: return a >> n;
      2'b11: return 32'($signed(a) >>> n);
      default: begin
`ifdef SHIFT_ROTATE_EN
        t = {a, a} >> n;
        return t[31:0];
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Transaction-level model: a request occupies n+1 edges including the
  // accepting one, then the result waits for out_ready.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (!m_busy && !m_done) begin
      if (in_valid) begin
        m_res <= model_result(A, B, Shiftop);
        if (B[4:0] == 5'd0) m_done <= 1'b1;
        else begin
          m_busy   <= 1'b1;
          m_remain <= int'(B[4:0]);
        end
      end
    end else if (m_busy) begin
      if (m_remain == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      m_remain <= m_remain - 1;
    end else if (out_ready) begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc in_ready", {31'd0, in_ready},
                  {31'd0, !rst && !m_busy && !m_done});
      checkOutput("cyc out_valid", {31'd0, out_valid}, {31'd0, !rst && m_done});
      checkOutput("cyc Result", Result, (!rst && m_done) ? m_res : 32'd0);
    end
  end

  // Issue one request, measure edges until out_valid, check literals.
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] op,
                               input int exp_edges, input logic [31:0] exp_res,
                               input bit handshake);
    int edges;
    bit seen;
    A = a; B = b; Shiftop = op; in_valid = 1'b1; out_ready = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      in_valid = 1'b0;
      // Operands change after acceptance and must not be resampled.
      A = $urandom; B = $urandom; Shiftop = 2'($urandom_range(3, 0));
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput({name, " latency"}, edges, exp_edges);
    checkOutput({name, " result"}, Result, exp_res);
    if (handshake) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] held;
    bit seen;

    $display("[TB] reset");
    checking = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset Result", Result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("first edge in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] directed shifts");
    applyStimulus("sll31", 32'h0000_0001, 32'd31, 2'b00, 32, 32'h8000_0000, 1'b1);
    applyStimulus("sra4", 32'h8000_0000, 32'd4, 2'b11, 5, 32'hF800_0000, 1'b1);
    applyStimulus("srl4", 32'h8000_0000, 32'd4, 2'b10, 5, 32'h0800_0000, 1'b1);
    applyStimulus("n0", 32'h1234_5678, 32'h0000_0020, 2'b00, 1, 32'h1234_5678, 1'b1);
    applyStimulus("sra3pos", 32'h7000_0000, 32'd3, 2'b11, 4, 32'h0E00_0000, 1'b1);
`ifdef SHIFT_ROTATE_EN
    applyStimulus("rotr1", 32'h0000_0003, 32'd1, 2'b01, 2, 32'h8000_0001, 1'b1);
`else
    applyStimulus("rotr1", 32'h0000_0003, 32'd1, 2'b01, 2, 32'h0000_0000, 1'b1);
`endif

    $display("[TB] hold in DONE");
    applyStimulus("hold", 32'h0000_00FF, 32'd3, 2'b00, 4, 32'h0000_07F8, 1'b0);
    held = Result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 in_valid = ~in_valid;
      A = $urandom; B = $urandom;
      @(negedge clk);
      checkOutput("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("hold stable", Result, 32'h0000_07F8);
    checkOutput("hold capture", held, 32'h0000_07F8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("hold released", {31'd0, in_ready}, 32'd1);

    $display("[TB] reset mid-shift");
    A = 32'h0000_0001; B = 32'd20; Shiftop = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort no valid", {31'd0, seen}, 32'd0);
    applyStimulus("after abort", 32'h0000_00F0, 32'd4, 2'b10, 5, 32'h0000_000F, 1'b1);

    $display("[TB] reset in DONE with out_ready");
    applyStimulus("done rst", 32'h0000_00AA, 32'd0, 2'b10, 1, 32'h0000_00AA, 1'b0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("done rst valid", {31'd0, out_valid}, 32'd0);
    checkOutput("done rst ready", {31'd0, in_ready}, 32'd1);
    applyStimulus("post rst", 32'hFFFF_0000, 32'd8, 2'b00, 9, 32'hFF00_0000, 1'b1);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
